muldiv_seq: RTL and testbench
=============================

MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width; 32 is the only supported value.
REQ-002 SHALL have port: clk  in  1  clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: start  in  1  request from ID stage, valid for one cycle.
REQ-005 SHALL have port: op  in  2  operation: 00 MULTU, 01 DIVU, 10 MTHI, 11 MTLO.
REQ-006 SHALL have port: a  in  32  operand A, forwarded rs value; dividend or multiplicand.
REQ-007 SHALL have port: b  in  32  operand B, forwarded rt value; divisor or multiplier.
REQ-008 SHALL have port: flush  in  1  cancel the in-flight operation; used on a branch or jump squash.
REQ-009 SHALL have port: busy  out  1  high whenever the state is not IDLE.
REQ-010 SHALL have port: stall  out  1  combinational freeze request to the ID/IF registers.
REQ-011 SHALL have port: done  out  1  one-cycle pulse signalling that HI/LO have been updated.
REQ-012 SHALL have port: dbz  out  1  divide-by-zero flag; valid only while done is high.
REQ-013 SHALL have ports: hi, lo  out  32 each  architectural HI and LO registers.

Function
REQ-014 SHALL implement FSM states IDLE, MUL, DIV and DONE.
REQ-015 SHALL use IDLE -> MUL when start=1 and op=00; IDLE -> DIV when start=1 and op=01.
REQ-016 In IDLE, start with op=10 SHALL write hi<=a at that edge, and op=11 SHALL write lo<=a; no state change, busy stays low, done stays low.
REQ-017 On acceptance, SHALL latch a and b internally and clear the 6-bit iteration counter; later changes on a and b SHALL be ignored.
REQ-018 MUL SHALL perform unsigned shift-add, one multiplier bit per edge, in a 64-bit accumulator.
REQ-019 DIV SHALL perform restoring division, one quotient bit per edge, with a 33-bit partial-remainder subtract.
REQ-020 After exactly 32 iteration edges, SHALL enter DONE and write hi/lo at that same edge.
- MULTU: hi = product[63:32], lo = product[31:0].
- DIVU: lo = quotient, hi = remainder.
REQ-021 Latency: start accepted at edge E0 -> hi/lo updated at E32 -> done=1 during the cycle after E32 -> IDLE at E33.
REQ-022 DONE SHALL last exactly one cycle and SHALL ignore start during that cycle.
REQ-023 Divide by zero: no special path. The algorithm SHALL yield lo=32'hFFFFFFFF and hi=a, with dbz=1 during done; latency SHALL be unchanged.
REQ-024 stall SHALL be 1 when state is MUL or DIV, or when state is IDLE with start=1 and op[1]=0. stall SHALL be 0 in DONE.
REQ-025 In MUL, DIV or DONE, start SHALL be ignored, with no queueing and no effect on the current operation.
REQ-026 flush=1 in MUL or DIV SHALL return the FSM to IDLE at the next edge, leave hi/lo unchanged, and keep done=0.
REQ-027 flush=1 in IDLE SHALL block acceptance of start at that edge, including MTHI/MTLO.
REQ-028 flush in DONE SHALL have no effect, because the results are already committed.
REQ-029 When flush and start are high in the same cycle, flush SHALL win.
REQ-030 The counter SHALL NOT wrap; reaching a count of 32 SHALL force the exit to DONE.

Reset
REQ-031 On rst, SHALL go to state IDLE and clear the counter.
REQ-032 On rst, SHALL clear hi, lo and the internal operand/accumulator registers to 0.
REQ-033 On rst, SHALL drive busy=0, done=0, dbz=0 and stall=0.
REQ-034 rst asserted mid-operation SHALL abort immediately; no partial result SHALL reach hi/lo.
REQ-035 After rst deasserts, the first start SHALL be accepted at the next rising edge.

Verification
REQ-036 SHALL test MULTU a=FFFFFFFF, b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001, done exactly 33 cycles after the start edge, and stall high for cycles 0..32.
REQ-037 SHALL test DIVU a=100, b=7 -> lo=14, hi=2, dbz=0.
REQ-038 SHALL test DIVU a=5, b=0 -> lo=FFFFFFFF, hi=5, dbz=1 with done.
REQ-039 SHALL test MTHI a=12345678, then MTLO a=9ABCDEF0 on back-to-back cycles -> hi=12345678, lo=9ABCDEF0, busy never asserted.
REQ-040 SHALL test MULTU 3*4 with a second start (DIVU) at iteration 5 and flush at iteration 10 -> IDLE next edge, hi/lo keep prior values, done never pulses.
REQ-041 SHALL test rst at iteration 20 of DIVU -> hi=lo=0, busy=0; a fresh MULTU 6*7 then yields lo=42, hi=0.

Source files
------------

// File: rtl/muldiv_seq.sv
// Sequential unsigned multiply/divide unit with architectural HI/LO registers.
// One multiplier or quotient bit per clock; 32 iterations per operation.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             dbz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t             state, state_nxt;
  logic [5:0]         cnt;
  logic [WIDTH-1:0]   op_a, op_b;
  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH+1:0]   div_diff;
  logic               dbz_q;
  logic               accept_mul, accept_div, write_hi, write_lo, last_iter;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    accept_mul = 1'b0;
    accept_div = 1'b0;
    write_hi   = 1'b0;
    write_lo   = 1'b0;
    last_iter  = (cnt == 6'(WIDTH - 1));
    acc_nxt    = acc;
    // acc holds {partial product, remaining multiplier} or {remainder, dividend/quotient}
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, op_a} : {(WIDTH+1){1'b0}});
    div_diff = {1'b0, acc[2*WIDTH-1:WIDTH-1]} - {2'b00, op_b};
    case (state)
      IDLE: begin
        if (start && !flush) begin
          case (op)
            2'b00: begin accept_mul = 1'b1; state_nxt = MUL; end
            2'b01: begin accept_div = 1'b1; state_nxt = DIV; end
            2'b10: write_hi = 1'b1;
            default: write_lo = 1'b1;
          endcase
        end
      end
      MUL: begin
        acc_nxt = {mul_sum, acc[WIDTH-1:1]};
        if (flush)          state_nxt = IDLE;
        else if (last_iter) state_nxt = DONE;
      end
      DIV: begin
        // borrow set means the trial subtract failed: restore by keeping the shifted value
        acc_nxt = div_diff[WIDTH+1] ? {acc[2*WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        if (flush)          state_nxt = IDLE;
        else if (last_iter) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      op_a  <= '0;
      op_b  <= '0;
      acc   <= '0;
      dbz_q <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      if (accept_mul || accept_div) begin
        op_a  <= a;
        op_b  <= b;
        cnt   <= '0;
        dbz_q <= 1'b0;
        acc   <= accept_mul ? {{WIDTH{1'b0}}, b} : {{WIDTH{1'b0}}, a};
      end
      if ((state == MUL || state == DIV) && !flush) begin
        acc <= acc_nxt;
        cnt <= cnt + 6'd1;
        if (last_iter) begin
          hi    <= acc_nxt[2*WIDTH-1:WIDTH];
          lo    <= acc_nxt[WIDTH-1:0];
          dbz_q <= (state == DIV) && (op_b == '0);
        end
      end
      if (write_hi) hi <= a;
      if (write_lo) lo <= a;
    end
  end

  assign busy  = (state != IDLE);
  assign done  = (state == DONE);
  assign dbz   = done && dbz_q;
  assign stall = !rst && ((state == MUL) || (state == DIV) ||
                          ((state == IDLE) && start && !op[1]));

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: expected HI/LO/dbz queued at issue,
// compared when done pulses.
module tb_muldiv_seq;

  logic        clk, rst, start, flush;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, stall, done, dbz;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_bad = 0;
  logic [64:0] sb_q[$];

  muldiv_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy), .stall(stall), .done(done), .dbz(dbz), .hi(hi), .lo(lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // scoreboard consumer
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb_q.size() == 0) begin
        chk("done_unexpected", 64'(done), 64'd0);
      end else begin
        logic [64:0] e;
        e = sb_q.pop_front();
        chk("hi", 64'(hi), 64'(e[64:33]));
        chk("lo", 64'(lo), 64'(e[32:1]));
        chk("dbz", 64'(dbz), 64'(e[0]));
      end
    end
  end

  task automatic do_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] eh, input logic [31:0] el, input logic ed);
    int lat, n_stall;
    logic stall_at_done;
    lat = -1;
    n_stall = 0;
    stall_at_done = 1'b1;
    sb_q.push_back({eh, el, ed});
    @(posedge clk); #1;
    start = 1'b1; op = o; a = av; b = bv;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (stall && k <= 32) n_stall++;
      if (done) begin
        lat = k;
        stall_at_done = stall;
        break;
      end
      @(posedge clk); #1;
      start = 1'b0; a = $urandom; b = $urandom;
    end
    chk("latency", 64'(lat), 64'd33);
    chk("stall_cycles", 64'(n_stall), 64'd33);
    chk("stall_in_done", 64'(stall_at_done), 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic do_model(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv);
    logic [63:0] p;
    if (o == 2'b00) begin
      p = 64'(av) * 64'(bv);
      do_op(o, av, bv, p[63:32], p[31:0], 1'b0);
    end else if (bv == 0) begin
      do_op(o, av, bv, av, 32'hFFFFFFFF, 1'b1);
    end else begin
      do_op(o, av, bv, av % bv, av / bv, 1'b0);
    end
  endtask

  initial begin
    logic busy_seen, done_seen;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dbz", 64'(dbz), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    do_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    do_op(2'b01, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    do_op(2'b01, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b1);
    for (int i = 0; i < 3; i++) begin
      do_model(2'b00, $urandom, $urandom);
      do_model(2'b01, $urandom, $urandom_range(1, 65535));
    end
    do_model(2'b01, 32'd7, 32'd9);

    // MTHI then MTLO back to back
    busy_seen = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; op = 2'b10; a = 32'h12345678;
    @(negedge clk);
    busy_seen |= busy;
    chk("mthi_stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    op = 2'b11; a = 32'h9ABCDEF0;
    @(negedge clk);
    busy_seen |= busy;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    busy_seen |= busy;
    chk("mt_busy", 64'(busy_seen), 64'd0);
    chk("mt_hilo", {hi, lo}, 64'h12345678_9ABCDEF0);

    // flush in IDLE blocks MTHI and MULTU
    @(posedge clk); #1;
    start = 1'b1; op = 2'b10; a = 32'hDEADBEEF; flush = 1'b1;
    @(posedge clk); #1;
    op = 2'b00;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("idle_flush_busy", 64'(busy), 64'd0);
    chk("idle_flush_hilo", {hi, lo}, 64'h12345678_9ABCDEF0);

    // MULTU 3*4, stray DIVU start at iteration 5, flush at iteration 10
    done_seen = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd4;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1 start = 1'b1; op = 2'b01; a = 32'd50; b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    chk("pre_flush_busy", 64'(busy), 64'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", 64'(busy), 64'd0);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      done_seen |= done;
    end
    chk("flush_no_done", 64'(done_seen), 64'd0);
    chk("flush_hilo", {hi, lo}, 64'h12345678_9ABCDEF0);

    // reset at iteration 20 of DIVU
    @(posedge clk); #1;
    start = 1'b1; op = 2'b01; a = 32'd1000; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_hilo", {hi, lo}, 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    do_op(2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);

    repeat (3) @(posedge clk);
    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
